// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: ALU select codes and
// the multiply/divide sequencer state type.
package mips_pkg;

  localparam logic [2:0] ALU_AND   = 3'b000;
  localparam logic [2:0] ALU_OR    = 3'b001;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_XOR   = 3'b011;
  localparam logic [2:0] ALU_SUB   = 3'b100;
  localparam logic [2:0] ALU_SHL   = 3'b101;
  localparam logic [2:0] ALU_SHR   = 3'b110;
  localparam logic [2:0] ALU_NOR   = 3'b111;

  localparam int MULDIV_ITER = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/result and borrowed-ALU bundle between the
// core top level (master) and the mul/div sequencer (slave).
interface muldiv_seq_if;

  logic        start;
  logic        op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        alu_own;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_c_in;
  logic [2:0]  alu_sel;
  logic [31:0] alu_r;
  logic        alu_cout_sum;

  modport master (
    output start, op, rs_val, rt_val,
    output alu_r, alu_cout_sum,
    input  busy, done, div_by_zero, hi, lo,
    input  alu_own, alu_a, alu_b, alu_c_in, alu_sel
  );

  modport slave (
    input  start, op, rs_val, rt_val,
    input  alu_r, alu_cout_sum,
    output busy, done, div_by_zero, hi, lo,
    output alu_own, alu_a, alu_b, alu_c_in, alu_sel
  );

endinterface

// File: rtl/alu32.sv
// Shared 32-bit ALU of the core; the adder carry-out is
// exported so the mul/div sequencer can iterate on it.
module alu32
  import mips_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  input  logic [2:0]  sel,
  output logic [31:0] r,
  output logic        cout_sum
);

  logic [32:0] sum;

  assign sum      = {1'b0, a} + {1'b0, b} + {32'd0, c_in};
  assign cout_sum = sum[32];

  always_comb begin
    r = sum[31:0];
    unique case (sel)
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_ADD: r = sum[31:0];
      ALU_XOR: r = a ^ b;
      ALU_SUB: r = a - b;
      ALU_SHL: r = a << b[4:0];
      ALU_SHR: r = a >> b[4:0];
      ALU_NOR: r = ~(a | b);
      default: r = sum[31:0];
    endcase
  end

endmodule

// File: rtl/muldiv_seq.sv
// Unsigned multu/divu sequencer: 32 shift-add or restoring
// shift-subtract steps on the borrowed shared ALU.
module muldiv_seq
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_seq_if.slave  bus
);

  muldiv_state_t    state, state_nx;
  logic [4:0]       cnt;
  logic [WIDTH-1:0] hi, lo, mcand, dvsr;
  logic [WIDTH-1:0] sh;
  logic             dbz;
  logic             ge;
  logic             last;

  assign sh   = {hi[WIDTH-2:0], lo[WIDTH-1]};
  assign ge   = hi[WIDTH-1] | bus.alu_cout_sum;
  assign last = (cnt == 5'(MULDIV_ITER - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    bus.alu_a    = '0;
    bus.alu_b    = '0;
    bus.alu_c_in = 1'b0;
    bus.alu_sel  = ALU_ADD;
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.op)                state_nx = S_MUL;
          else if (bus.rt_val == '0) state_nx = S_DONE;
          else                       state_nx = S_DIV;
        end
      end
      S_MUL: begin
        bus.alu_a = hi;
        bus.alu_b = mcand;
        if (last) state_nx = S_DONE;
      end
      S_DIV: begin
        bus.alu_a    = sh;
        bus.alu_b    = ~dvsr;
        bus.alu_c_in = 1'b1;
        if (last) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      mcand <= '0;
      dvsr  <= '0;
      dbz   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            cnt <= '0;
            dbz <= 1'b0;
            if (bus.op) begin
              hi    <= '0;
              lo    <= bus.rt_val;
              mcand <= bus.rs_val;
            end else if (bus.rt_val != '0) begin
              hi   <= '0;
              lo   <= bus.rs_val;
              dvsr <= bus.rt_val;
            end else begin
              hi  <= bus.rs_val;
              lo  <= '1;
              dbz <= 1'b1;
            end
          end
        end
        S_MUL: begin
          cnt <= cnt + 5'd1;
          // carry-out becomes the new top bit of hi on the shift
          if (lo[0])
            {hi, lo} <= {bus.alu_cout_sum, bus.alu_r,
                         lo[WIDTH-1:1]};
          else
            {hi, lo} <= {1'b0, hi, lo[WIDTH-1:1]};
        end
        S_DIV: begin
          cnt <= cnt + 5'd1;
          if (ge) begin
            hi <= bus.alu_r;
            lo <= {lo[WIDTH-2:0], 1'b1};
          end else begin
            hi <= sh;
            lo <= {lo[WIDTH-2:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state != S_IDLE);
  assign bus.done        = (state == S_DONE);
  assign bus.alu_own     = (state == S_MUL) || (state == S_DIV);
  assign bus.hi          = hi;
  assign bus.lo          = lo;
  assign bus.div_by_zero = dbz;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq with the real alu32 behind the
// alu_own operand mux; reference model uses plain arithmetic.
module tb_muldiv_seq;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_seq_if ifc ();

  logic [31:0] cpu_a = 32'hDEAD_BEEF;
  logic [31:0] cpu_b = 32'h0F0F_0F0F;
  logic [31:0] a_m, b_m;
  logic        c_m;
  logic [2:0]  s_m;

  assign a_m = ifc.alu_own ? ifc.alu_a    : cpu_a;
  assign b_m = ifc.alu_own ? ifc.alu_b    : cpu_b;
  assign c_m = ifc.alu_own ? ifc.alu_c_in : 1'b0;
  assign s_m = ifc.alu_own ? ifc.alu_sel  : ALU_XOR;

  alu32 u_alu (
    .a        (a_m),
    .b        (b_m),
    .c_in     (c_m),
    .sel      (s_m),
    .r        (ifc.alu_r),
    .cout_sum (ifc.alu_cout_sum)
  );

  muldiv_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ref_model(input logic o,
                           input logic [31:0] a,
                           input logic [31:0] b,
                           output logic [31:0] eh,
                           output logic [31:0] el,
                           output logic ed);
    logic [63:0] p;
    ed = 1'b0;
    if (o) begin
      p  = 64'(a) * 64'(b);
      eh = p[63:32];
      el = p[31:0];
    end else if (b == 32'd0) begin
      eh = a;
      el = 32'hFFFF_FFFF;
      ed = 1'b1;
    end else begin
      eh = a % b;
      el = a / b;
    end
  endtask

  task automatic run_op(input logic o,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input string tag);
    logic [31:0] eh, el;
    logic        ed;
    int          lat, bsy, elat;
    bit          own;
    ref_model(o, a, b, eh, el, ed);
    elat = ed ? 1 : 33;
    @(posedge clk); #1;
    ifc.start  = 1'b1;
    ifc.op     = o;
    ifc.rs_val = a;
    ifc.rt_val = b;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    chk({tag, ":dbz_e1"}, 64'(ifc.div_by_zero), 64'(ed));
    lat = 1; bsy = 0; own = 1'b0;
    while (!ifc.done && lat < 40) begin
      bsy += int'(ifc.busy);
      own |= ifc.alu_own;
      @(posedge clk); #1;
      lat++;
    end
    bsy += int'(ifc.busy);
    own |= ifc.alu_own;
    chk({tag, ":latency"}, 64'(lat), 64'(elat));
    chk({tag, ":busy_cycles"}, 64'(bsy), 64'(elat));
    chk({tag, ":alu_own"}, 64'(own), 64'(!ed));
    chk({tag, ":hi"}, 64'(ifc.hi), 64'(eh));
    chk({tag, ":lo"}, 64'(ifc.lo), 64'(el));
    chk({tag, ":dbz"}, 64'(ifc.div_by_zero), 64'(ed));
    @(posedge clk); #1;
    chk({tag, ":done_pulse"},
        64'({ifc.done, ifc.busy}), 64'(0));
    chk({tag, ":hold"}, {ifc.hi, ifc.lo}, {eh, el});
  endtask

  initial begin
    logic [31:0] eh, el, ra, rb;
    logic        ed, ro;
    int          lat;
    bit          seen;

    reset      = 1'b1;
    ifc.start  = 1'b0;
    ifc.op     = 1'b0;
    ifc.rs_val = '0;
    ifc.rt_val = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset:flags", 64'({ifc.busy, ifc.done,
        ifc.div_by_zero, ifc.alu_own}), 64'(0));
    chk("reset:hilo", {ifc.hi, ifc.lo}, 64'(0));
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle:alu_ab", {ifc.alu_a, ifc.alu_b}, 64'(0));
    chk("idle:alu_ctl", 64'({ifc.alu_c_in, ifc.alu_sel}),
        64'({1'b0, ALU_ADD}));

    run_op(1'b1, 32'd7, 32'd6, "mul7x6");
    run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_max");
    run_op(1'b0, 32'd100, 32'd7, "div100_7");
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, "div_max_1");
    run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, "div_hi31");
    run_op(1'b0, 32'd5, 32'd0, "div5_0");
    run_op(1'b1, 32'd2, 32'd21, "mul_after_dbz");

    // start pulsed mid-multiply must not disturb the result
    ref_model(1'b1, 32'h1234_5678, 32'h9ABC, eh, el, ed);
    @(posedge clk); #1;
    ifc.start  = 1'b1;
    ifc.op     = 1'b1;
    ifc.rs_val = 32'h1234_5678;
    ifc.rt_val = 32'h9ABC;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    ifc.start  = 1'b1;
    ifc.op     = 1'b0;
    ifc.rs_val = 32'd1;
    ifc.rt_val = 32'd0;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    lat = 11;
    while (!ifc.done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("ignore:latency", 64'(lat), 64'(33));
    chk("ignore:result", {ifc.hi, ifc.lo}, {eh, el});
    chk("ignore:dbz", 64'(ifc.div_by_zero), 64'(0));
    @(posedge clk); #1;

    // asynchronous reset in the middle of a divide
    @(posedge clk); #1;
    ifc.start  = 1'b1;
    ifc.op     = 1'b0;
    ifc.rs_val = 32'd1000;
    ifc.rt_val = 32'd3;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    repeat (19) @(posedge clk);
    #3;
    chk("pre_rst:busy", 64'(ifc.busy), 64'(1));
    reset = 1'b1;
    #1;
    chk("mid_rst:flags", 64'({ifc.busy, ifc.done,
        ifc.div_by_zero, ifc.alu_own}), 64'(0));
    chk("mid_rst:hilo", {ifc.hi, ifc.lo}, 64'(0));
    chk("mid_rst:alu", {ifc.alu_a, ifc.alu_b}, 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen |= ifc.done;
    end
    chk("mid_rst:no_done", 64'(seen), 64'(0));
    run_op(1'b1, 32'd3, 32'd3, "mul3x3");

    for (int i = 0; i < 16; i++) begin
      ro = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 50));
        2:       ra = 32'($urandom_range(0, 1000));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 5) == 2) rb = $urandom;
      run_op(ro, ra, rb, $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
